// File: rtl/oam_dma_controller.sv
// OAM DMA controller: on a CPU write to $4014 it halts the CPU and copies one
// 256-byte page to $2004 as alternating read/write bus cycles.
module oam_dma_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_data_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_rw,
    output logic        cpu_rdy,
    output logic        dma_active
);

    localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR    = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } state_e;

    state_e      state_q;
    logic        parity_q;
    logic [7:0]  page_q;
    logic [7:0]  count_q;
    logic [7:0]  data_q;
    logic        start_req;

    // Only a CPU write to the trigger register starts a transfer; reads and other
    // addresses are ordinary bus traffic.
    assign start_req = (cpu_rw == 1'b0) && (cpu_addr == DMA_TRIGGER_ADDR);

    // NOTE: every register here uses non-blocking assignment so all of them
    // update together on the clock edge, whatever order the statements are in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            count_q  <= 8'h00;
            data_q   <= 8'h00;
        end else begin
            parity_q <= ~parity_q;
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        page_q  <= cpu_data_out;
                        count_q <= 8'h00;
                        state_q <= ST_HALT;
                    end
                end
                // The next cycle's parity is ~parity_q; a read must land on a
                // parity-0 cycle, otherwise burn one extra alignment cycle.
                ST_HALT:  state_q <= parity_q ? ST_READ : ST_ALIGN;
                ST_ALIGN: state_q <= ST_READ;
                ST_READ: begin
                    data_q  <= bus_data_in;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    count_q <= count_q + 8'd1;
                    state_q <= (count_q == 8'hFF) ? ST_IDLE : ST_READ;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake flags depend on registered state only, so the CPU never sees
    // a combinational path from its own bus to its ready input.
    assign cpu_rdy    = (state_q == ST_IDLE);
    assign dma_active = ~cpu_rdy;

    // NOTE: each output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        bus_addr     = cpu_addr;
        bus_data_out = cpu_data_out;
        bus_rw       = cpu_rw;
        case (state_q)
            ST_IDLE: ;
            ST_HALT, ST_ALIGN: begin
                bus_rw       = 1'b1;
                bus_data_out = 8'h00;
            end
            ST_READ: begin
                bus_addr     = {page_q, count_q};
                bus_rw       = 1'b1;
                bus_data_out = 8'h00;
            end
            ST_WRITE: begin
                bus_addr     = OAM_DATA_ADDR;
                bus_rw       = 1'b0;
                bus_data_out = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/oam_dma_controller.md
OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock (CPU rate); all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; asserted clears all state immediately.
REQ-003 SHALL have port cpu_addr, input, 16 bits: CPU address bus.
REQ-004 SHALL have port cpu_data_out, input, 8 bits: CPU write data.
REQ-005 SHALL have port cpu_rw, input, 1 bit: CPU direction (0=write, 1=read).
REQ-006 SHALL have port bus_data_in, input, 8 bits: system read data from memory.
REQ-007 SHALL have port bus_addr, output, 16 bits: arbitrated system address.
REQ-008 SHALL have port bus_data_out, output, 8 bits: arbitrated write data.
REQ-009 SHALL have port bus_rw, output, 1 bit: arbitrated direction (0=write, 1=read).
REQ-010 SHALL have port cpu_rdy, output, 1 bit: 1=CPU may advance; 0=CPU holds all registers.
REQ-011 SHALL have port dma_active, output, 1 bit: 1 while a transfer is in progress.

Function
REQ-012 SHALL keep a parity flop that toggles every cycle and is 0 in the first cycle after reset release; parity 0 = "get" cycle, parity 1 = "put" cycle.
REQ-013 SHALL implement states IDLE, HALT, ALIGN, READ and WRITE, encoded in a registered state.
REQ-014 In IDLE, when cpu_rw=0 and cpu_addr=16'h4014, SHALL latch page=cpu_data_out, clear the 8-bit count and go to HALT.
REQ-015 HALT SHALL last one cycle, then go to READ if the next cycle's parity is 0, otherwise to ALIGN.
REQ-016 ALIGN SHALL last one cycle, then go to READ.
REQ-017 READ SHALL drive bus_addr={page,count} and bus_rw=1, latch bus_data_in into an 8-bit data latch, and go to WRITE.
REQ-018 WRITE SHALL drive bus_addr=16'h2004, bus_rw=0 and bus_data_out=data latch, then increment count modulo 256.
REQ-019 After WRITE, SHALL go to IDLE if count was 8'hFF before the increment, else to READ.
REQ-020 In HALT and ALIGN, SHALL pass cpu_addr through to bus_addr, force bus_rw=1 and drive bus_data_out=8'h00 (dummy read).
REQ-021 In IDLE, SHALL pass bus_addr=cpu_addr, bus_data_out=cpu_data_out and bus_rw=cpu_rw through combinationally.
REQ-022 SHALL drive cpu_rdy=1 exactly when state=IDLE, and dma_active as its inverse; both are decoded from registered state only.
REQ-023 Total halt SHALL be 513 cycles when the $4014 write occurs on an even (parity 0) cycle and 514 cycles when it occurs on an odd cycle.
REQ-024 Writes to $4014 outside IDLE SHALL be ignored; the page latch SHALL NOT change during a transfer.
REQ-025 CPU reads of $4014, and CPU writes to any other address, SHALL NOT start a transfer.
REQ-026 Page 8'hFF SHALL read addresses $FF00-$FFFF with no wrap into page 0.

Reset
REQ-027 While reset=1, SHALL hold state=IDLE, parity=0, count=0, page=0, data latch=0, cpu_rdy=1 and dma_active=0, with bus outputs in passthrough.
REQ-028 Reset asserted mid-transfer SHALL abort immediately, perform no further $2004 writes, and return cpu_rdy=1 asynchronously.

Verification
REQ-029 After reset, write $02 to $4014 in cycle 0: cpu_rdy=0 for cycles 1-513; READ of $0200 in cycle 2; final WRITE to $2004 in cycle 513; cpu_rdy=1 in cycle 514.
REQ-030 Write $02 to $4014 in cycle 1: an ALIGN cycle occurs in cycle 3; the first READ is in cycle 4; cpu_rdy=0 for exactly 514 cycles.
REQ-031 Preload memory $0300+i=i^8'h5A and DMA page $03: observe 256 writes to $2004 with data i^8'h5A, in order i=0..255.
REQ-032 Issue a second $4014 write (forced on the CPU bus) during a transfer: no restart occurs, and the page and total duration are unchanged.
REQ-033 Assert reset after 100 $2004 writes: cpu_rdy=1 and dma_active=0 immediately; no further $2004 writes; after release, a new $4014 write starts with count=0.
REQ-034 In IDLE, CPU read of $4014 and CPU write to $4015: no halt occurs, and the bus outputs equal the CPU signals every cycle.
